// File: rtl/xnor_pkg.sv
// Shared types and helpers for the streaming XNOR correlator.
package xnor_pkg;

  typedef enum logic {FILL, RUN} state_t;

  // Score width needed to hold 0..n inclusive.
  function automatic int sw_of(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) n += {31'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Combinational compare array (XNOR, or XOR when xor_mode) reduced to a popcount.
module xnor_popcount import xnor_pkg::*; #(
  parameter int  N  = 16,
  localparam int SW = sw_of(N)
) (
  input  logic [N-1:0]  window,
  input  logic [N-1:0]  pattern,
  input  logic          xor_mode,
  output logic [SW-1:0] score
);

  logic [N-1:0] c;

  for (genvar i = 0; i < N; i++) begin : g_cmp
    assign c[i] = ~(window[i] ^ pattern[i]) ^ xor_mode;
  end

  assign score = SW'(popcount(64'(c)));

endmodule

// File: rtl/xnor_correlator.sv
// Serial sync-word detector: shift window, fill/run FSM, one-stage scored result, match counter.
module xnor_correlator import xnor_pkg::*; #(
  parameter int  N  = 16,
  parameter int  CW = 8,
  localparam int SW = sw_of(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_bit,
  input  logic          pat_load,
  input  logic [N-1:0]  pat_in,
  input  logic [SW-1:0] thresh,
  input  logic          xor_mode,
  output logic          out_valid,
  output logic [SW-1:0] score,
  output logic          match,
  output logic          window_full,
  output logic [CW-1:0] match_count
);

  localparam int STAGES = 1;

  state_t          state;
  logic [N-1:0]    window, pattern;
  logic [SW-1:0]   fill, thr_q, score_next;
  logic            xor_q;
  logic [STAGES:0] vld_pipe;
  logic            accept, completes, hit;

  assign accept    = in_valid & ~pat_load;
  // The accepted bit yields a result once it is the Nth (or later) since flush.
  assign completes = (state == RUN) || (fill == SW'(N - 1));

  xnor_popcount #(.N(N)) u_pop (
    .window   (window),
    .pattern  (pattern),
    .xor_mode (xor_q),
    .score    (score_next)
  );

  // A pat_load squashes the result that would otherwise retire this edge.
  assign hit = vld_pipe[0] & ~pat_load & (score_next >= thr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      window      <= '0;
      pattern     <= '0;
      fill        <= '0;
      thr_q       <= '0;
      xor_q       <= 1'b0;
      vld_pipe    <= '0;
      score       <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      vld_pipe[0] <= accept & completes;
      for (int s = 1; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1] & ~pat_load;

      if (pat_load) begin
        pattern <= pat_in;
        window  <= '0;
        fill    <= '0;
        state   <= FILL;
      end else if (in_valid) begin
        window <= {window[N-2:0], in_bit};
        thr_q  <= thresh;
        xor_q  <= xor_mode;
        if (state == FILL) begin
          fill <= fill + 1'b1;
          if (fill == SW'(N - 1)) state <= RUN;
        end
      end

      match <= hit;
      if (vld_pipe[0] && !pat_load) score <= score_next;
      if (hit && match_count != '1) match_count <= match_count + 1'b1;
    end
  end

  assign out_valid   = vld_pipe[STAGES];
  assign window_full = (state == RUN);

endmodule
